// File: rtl/tx_word_packer.sv
// Walks a completed transaction buffer, strips the opcode/length header and
// streams the payload as little-endian 32-bit words over valid/ready.
//
// state | meaning
// IDLE  | waiting for inStart; byteAddr parked at 0
// OP    | latching opcode from buffer byte 0
// LEN   | checking payload length against the byte count
// FILL  | packing one payload byte per cycle into outWord
// SEND  | outWord offered downstream, held until accepted
module tx_word_packer #(
   parameter int ADDR_W     = 8,
   parameter int WORD_BYTES = 4
) (
   input  logic                    inTCK,
   input  logic                    inRSTn,
   input  logic                    inStart,
   input  logic [ADDR_W:0]         inByteCount,
   output logic [ADDR_W-1:0]       byteAddr,
   input  logic [7:0]              inByte,
   output logic [7:0]              outOpcode,
   output logic [8*WORD_BYTES-1:0] outWord,
   output logic                    outValid,
   input  logic                    inReady,
   output logic                    outLast,
   output logic                    outDone,
   output logic                    outBusy,
   output logic                    outErr,
   output logic                    outOverrun
);

   localparam int                 LANE_W    = 2;
   localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(WORD_BYTES - 1);
   localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {IDLE, OP, LEN, FILL, SEND} stateT;

   stateT                   state, stateNxt;
   logic [ADDR_W:0]         cnt, cntNxt;
   logic [7:0]              rem, remNxt;
   logic [LANE_W-1:0]       lane, laneNxt;
   logic [ADDR_W-1:0]       addrNxt;
   logic [7:0]              opNxt;
   logic [8*WORD_BYTES-1:0] wordNxt;
   logic                    lastNxt, doneNxt, errNxt, ovrNxt;
   logic [ADDR_W+1:0]       lenPlus2;

   assign outValid = (state == SEND);
   assign outBusy  = (state != IDLE);
   // One bit wider than cnt so a 255-byte length cannot wrap the compare.
   assign lenPlus2 = (ADDR_W+2)'(inByte) + (ADDR_W+2)'(2);

   always_ff @(posedge inTCK or negedge inRSTn) begin
      if (!inRSTn) begin
         state      <= IDLE;
         cnt        <= '0;
         rem        <= '0;
         lane       <= '0;
         byteAddr   <= '0;
         outOpcode  <= '0;
         outWord    <= '0;
         outLast    <= 1'b0;
         outDone    <= 1'b0;
         outErr     <= 1'b0;
         outOverrun <= 1'b0;
      end else begin
         state      <= stateNxt;
         cnt        <= cntNxt;
         rem        <= remNxt;
         lane       <= laneNxt;
         byteAddr   <= addrNxt;
         outOpcode  <= opNxt;
         outWord    <= wordNxt;
         outLast    <= lastNxt;
         outDone    <= doneNxt;
         outErr     <= errNxt;
         outOverrun <= ovrNxt;
      end
   end

   always_comb begin
      stateNxt = state;
      cntNxt   = cnt;
      remNxt   = rem;
      laneNxt  = lane;
      addrNxt  = byteAddr;
      opNxt    = outOpcode;
      wordNxt  = outWord;
      lastNxt  = outLast;
      doneNxt  = 1'b0;
      errNxt   = outErr;
      ovrNxt   = outOverrun | (inStart && (state != IDLE));
      case (state)
         IDLE: begin
            addrNxt = '0;
            if (inStart) begin
               errNxt = 1'b0;
               cntNxt = inByteCount;
               if (inByteCount < (ADDR_W+1)'(2)) errNxt = 1'b1;
               else                             stateNxt = OP;
            end
         end
         OP: begin
            opNxt    = inByte;
            addrNxt  = ADDR_ONE;
            stateNxt = LEN;
         end
         LEN: begin
            if (lenPlus2 > {1'b0, cnt}) begin
               errNxt   = 1'b1;
               addrNxt  = '0;
               stateNxt = IDLE;
            end else if (inByte == 8'd0) begin
               doneNxt  = 1'b1;
               addrNxt  = '0;
               stateNxt = IDLE;
            end else begin
               remNxt   = inByte;
               addrNxt  = ADDR_W'(2);
               laneNxt  = '0;
               wordNxt  = '0;
               stateNxt = FILL;
            end
         end
         FILL: begin
            wordNxt[{lane, 3'b000} +: 8] = inByte;
            remNxt  = rem - 8'd1;
            laneNxt = lane + 2'd1;
            // Hold the address on the final byte so a full buffer never wraps.
            if (rem != 8'd1) addrNxt = byteAddr + ADDR_ONE;
            if ((lane == LAST_LANE) || (rem == 8'd1)) begin
               lastNxt  = (rem == 8'd1);
               stateNxt = SEND;
            end
         end
         SEND: begin
            if (inReady) begin
               if (outLast) begin
                  lastNxt  = 1'b0;
                  doneNxt  = 1'b1;
                  addrNxt  = '0;
                  stateNxt = IDLE;
               end else begin
                  laneNxt  = '0;
                  wordNxt  = '0;
                  stateNxt = FILL;
               end
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tx_word_packer.sv
// Directed bench for tx_word_packer: buffer model behind byteAddr, consumer
// with optional back-pressure, and hand-computed expected words.
module tb_tx_word_packer;

   logic        inTCK = 1'b0;
   logic        inRSTn = 1'b0;
   logic        inStart = 1'b0;
   logic        inReady = 1'b1;
   logic [8:0]  inByteCount = '0;
   logic [7:0]  byteAddr, inByte, outOpcode;
   logic [31:0] outWord;
   logic        outValid, outLast, outDone, outBusy, outErr, outOverrun;

   logic [7:0]  mem [256];
   int          nErr = 0;
   int          nChecks = 0;
   int          nWords, nDone, firstValid, nBusy, stableBad;
   logic [31:0] gotW [8];
   logic        gotL [8];

   always #5 inTCK = ~inTCK;
   assign inByte = mem[byteAddr];

   tx_word_packer #(.ADDR_W(8), .WORD_BYTES(4)) dut (
      .inTCK(inTCK), .inRSTn(inRSTn), .inStart(inStart),
      .inByteCount(inByteCount), .byteAddr(byteAddr), .inByte(inByte),
      .outOpcode(outOpcode), .outWord(outWord), .outValid(outValid),
      .inReady(inReady), .outLast(outLast), .outDone(outDone),
      .outBusy(outBusy), .outErr(outErr), .outOverrun(outOverrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge inTCK);
      #1;
   endtask

   task automatic startTx(input logic [8:0] n);
      inByteCount = n;
      inStart     = 1'b1;
      tick();
      inStart     = 1'b0;
   endtask

   task automatic loadCase1();
      mem[0] = 8'hA5; mem[1] = 8'h05; mem[2] = 8'h11; mem[3] = 8'h22;
      mem[4] = 8'h33; mem[5] = 8'h44; mem[6] = 8'h55;
   endtask

   // k counts edges since the edge that accepted inStart.
   task automatic collect(input int budget, input int stall, input int pulseAt);
      int stallLeft;
      stallLeft  = stall;
      nWords     = 0;
      nDone      = 0;
      firstValid = -1;
      nBusy      = 0;
      stableBad  = 0;
      for (int k = 0; k < budget; k++) begin
         inStart = (k == pulseAt);
         if (outValid && firstValid < 0) firstValid = k;
         if (outBusy) nBusy++;
         if (outDone) nDone++;
         if (firstValid >= 0 && stallLeft > 0) begin
            inReady = 1'b0;
            stallLeft--;
            if (!outValid || outWord !== 32'h44332211) stableBad++;
         end else begin
            inReady = 1'b1;
         end
         if (outValid && inReady && nWords < 8) begin
            gotW[nWords] = outWord;
            gotL[nWords] = outLast;
            nWords++;
         end
         tick();
      end
      inStart = 1'b0;
      inReady = 1'b1;
   endtask

   task automatic checkCase1(input string p);
      check({p, "_opcode"}, 32'(outOpcode), 32'hA5);
      check({p, "_nwords"}, 32'(nWords), 32'd2);
      check({p, "_w0"}, gotW[0], 32'h44332211);
      check({p, "_l0"}, 32'(gotL[0]), 32'd0);
      check({p, "_w1"}, gotW[1], 32'h00000055);
      check({p, "_l1"}, 32'(gotL[1]), 32'd1);
      check({p, "_done"}, 32'(nDone), 32'd1);
      check({p, "_latency"}, 32'(firstValid), 32'd6);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      #1;
      check("rst_addr", 32'(byteAddr), 32'd0);
      check("rst_word", outWord, 32'd0);
      check("rst_opcode", 32'(outOpcode), 32'd0);
      check("rst_flags", 32'({outValid, outLast, outDone, outBusy, outErr, outOverrun}), 32'd0);
      #3 inRSTn = 1'b1;
      tick();

      loadCase1();
      startTx(9'd7);
      collect(20, 0, -1);
      checkCase1("c1");

      startTx(9'd7);
      collect(40, 10, -1);
      check("c2_stable", 32'(stableBad), 32'd0);
      check("c2_nwords", 32'(nWords), 32'd2);
      check("c2_w0", gotW[0], 32'h44332211);
      check("c2_w1", gotW[1], 32'h00000055);
      check("c2_done", 32'(nDone), 32'd1);

      mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'hAA; mem[3] = 8'hBB;
      startTx(9'd4);
      collect(10, 0, -1);
      check("c3_err", 32'(outErr), 32'd1);
      check("c3_novalid", 32'(firstValid), 32'hFFFFFFFF);
      check("c3_nodone", 32'(nDone), 32'd0);
      check("c3_busy", 32'(nBusy), 32'd2);

      mem[0] = 8'h07; mem[1] = 8'h00;
      startTx(9'd2);
      collect(10, 0, -1);
      check("c4_errclr", 32'(outErr), 32'd0);
      check("c4_novalid", 32'(firstValid), 32'hFFFFFFFF);
      check("c4_done", 32'(nDone), 32'd1);
      check("c4_busy", 32'(nBusy), 32'd2);
      check("c4_opcode", 32'(outOpcode), 32'h07);

      startTx(9'd1);
      check("c4b_err", 32'(outErr), 32'd1);
      collect(5, 0, -1);
      check("c4b_busy", 32'(nBusy), 32'd0);
      check("c4b_opcode", 32'(outOpcode), 32'h07);

      loadCase1();
      check("c5_ovr_pre", 32'(outOverrun), 32'd0);
      startTx(9'd7);
      collect(20, 0, 3);
      checkCase1("c5");
      check("c5_ovr", 32'(outOverrun), 32'd1);

      startTx(9'd7);
      for (int k = 0; k < 20; k++) begin
         if (outValid) break;
         tick();
      end
      check("c6_reach_send", 32'(outValid), 32'd1);
      #2 inRSTn = 1'b0;
      #1;
      check("c6_rst_valid", 32'(outValid), 32'd0);
      check("c6_rst_busy", 32'(outBusy), 32'd0);
      check("c6_rst_addr", 32'(byteAddr), 32'd0);
      check("c6_rst_ovr", 32'(outOverrun), 32'd0);
      #2 inRSTn = 1'b1;
      tick();
      startTx(9'd7);
      collect(20, 0, -1);
      checkCase1("c6");

      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end

endmodule

// File: doc/tx_word_packer.md
Name: tx_word_packer

Overview:
- Downstream stage of the host byte deserializer.
- After a host transaction completes, walks the deserializer's transaction buffer through its byte-address/byte-data read port and parses a 2-byte header (opcode, payload length).
- Packs the payload little-endian into 32-bit words and streams them to the CNN datapath over a valid/ready handshake.
- Flags malformed transactions and transaction starts that arrive while busy.

Parameters:
- ADDR_W, 8, byte-address width of the transaction buffer (buffer depth 2^ADDR_W = 256 bytes).
- WORD_BYTES, 4, bytes per output word; outWord width is 8*WORD_BYTES. Only 4 is supported.

Ports:
- inTCK  input  1  clock; all state changes on its rising edge.
- inRSTn  input  1  asynchronous active-low reset.
- inStart  input  1  one-cycle pulse: transaction buffer complete and readable.
- inByteCount  input  ADDR_W+1  number of valid bytes in the buffer (0..256); sampled on an accepted inStart.
- byteAddr  output  ADDR_W  read address into the transaction buffer.
- inByte  input  8  buffer data at byteAddr, combinational, same cycle.
- outOpcode  output  8  opcode (buffer byte 0) of the current/last transaction.
- outWord  output  32  packed payload word.
- outValid  output  1  outWord valid.
- inReady  input  1  consumer accepts outWord.
- outLast  output  1  qualifies outWord as the final word of the payload.
- outDone  output  1  one-cycle pulse: transaction fully consumed.
- outBusy  output  1  high in every state except IDLE.
- outErr  output  1  sticky malformed-transaction flag.
- outOverrun  output  1  sticky start-while-busy flag.

Behaviour:
- Reset (asynchronous, immediate, in any state): state=IDLE; byteAddr, outOpcode and outWord = 0; outValid, outLast, outDone, outBusy, outErr and outOverrun = 0.
- Registers: cnt (9b), rem (8b, payload bytes left), lane (2b), byteAddr (8b).

States:
- IDLE:
  - byteAddr=0.
  - On inStart: outErr cleared; cnt<=inByteCount.
  - If inByteCount<2: outErr<=1, stay in IDLE, outDone not pulsed.
  - Otherwise -> OP.
- OP: outOpcode<=inByte (addr 0); byteAddr<=1; -> LEN.
- LEN: evaluate L=inByte.
  - If L+2 > cnt (9-bit compare): outErr<=1, -> IDLE, no outDone.
  - If L==0: outDone pulse, -> IDLE.
  - Otherwise: rem<=L; byteAddr<=2; lane<=0; outWord<=0; -> FILL.
- FILL:
  - Each cycle: outWord[8*lane+7:8*lane] <= inByte; byteAddr++; rem--; lane++.
  - Exit when lane==3 or rem==1 (i.e., this is the last byte): -> SEND; outLast <= (rem==1).
  - Unused upper lanes stay 0.
- SEND:
  - outValid=1; outWord and outLast held stable until inValid&&inReady handshake (outValid & inReady on a rising edge).
  - On handshake with outLast=1: outValid<=0, outLast<=0, outDone pulse, -> IDLE.
  - On handshake with outLast=0: outValid<=0, lane<=0, outWord<=0, -> FILL.
  - outValid never drops without a handshake.

Rules:
- Max legal payload is L=254 (cnt ≤ 256), so byteAddr never exceeds 255 and never wraps.
- Throughput: one word per ≥5 cycles (4 FILL + 1 SEND). Latency from inStart to first outValid = 2 + min(L,4) cycles.
- inStart while outBusy=1: ignored; outOverrun<=1 (cleared only by reset); the current transaction continues unaffected.
- inStart in the same cycle as the final handshake: not accepted (state is still SEND); outOverrun set.
- Header bytes are never emitted. outOpcode holds its value until the next accepted start reaches OP.

Test Plan:
1. cnt=7, buffer A5 05 11 22 33 44 55, inReady=1: outOpcode=A5; words 0x44332211 (last=0) then 0x00000055 (last=1); one outDone pulse; first outValid 6 cycles after inStart.
2. Same stimulus, inReady low for 10 cycles during the first SEND: outValid stays high and outWord stays 0x44332211 throughout; exactly 2 handshakes total.
3. cnt=4, buffer 01 05 AA BB: outErr=1, no outValid, no outDone, back in IDLE 2 cycles after inStart. Next valid start clears outErr.
4. cnt=2, buffer 07 00: no outValid, outDone pulses, outBusy high exactly 2 cycles. cnt=1 start: outErr=1 immediately, outBusy never rises.
5. inStart pulsed during FILL of case 1: outOverrun=1; the word sequence is identical to case 1.
6. inRSTn asserted mid-SEND: outValid, outBusy and byteAddr go to 0 before the next clock edge; a fresh start after release reproduces case 1.
